// File: rtl/dbg_cmd_pkg.sv
// Debug-host command set, FSM states and reply constants
// shared by the UART debug bus controller.
package dbg_cmd_pkg;

  localparam logic [7:0] DBG_HALT   = 8'h00;
  localparam logic [7:0] DBG_RESUME = 8'h01;
  localparam logic [7:0] DBG_WRITE  = 8'h02;
  localparam logic [7:0] DBG_READ   = 8'h03;

  localparam logic [7:0] DBG_NOHALT_REPLY = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_AH,
    S_GET_AL,
    S_GET_DATA,
    S_BUS_WR,
    S_BUS_RD,
    S_RD_WAIT,
    S_TX_REQ,
    S_TX_WAIT
  } dbg_state_e;

endpackage

// File: rtl/dbg_timeout_ctr.sv
// Reloadable down-counter; expire strobes after CYC enabled
// cycles without a kick. Used only when DBG_TIMEOUT_EN is set.
module dbg_timeout_ctr #(
  parameter int CYC = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic expire
);

  localparam int W = $clog2(CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= W'(CYC - 1);
    end else if (!en || kick) begin
      cnt <= W'(CYC - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && !kick && (cnt == '0);

endmodule

// File: rtl/uart_dbg_bus_ctrl.sv
// UART debug host: halts the CPU, owns the bus and runs single-byte
// writes/reads. Optional inter-byte timeout under DBG_TIMEOUT_EN.
import dbg_cmd_pkg::*;

module uart_dbg_bus_ctrl #(
  parameter int READ_LAT    = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_active,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_halt,
  output logic        dbg_grant,
  output logic [7:0]  err_cnt
);

  dbg_state_e  state, state_n;
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        is_wr;
  logic [1:0]  rd_cnt;

  logic       halt_set, resume, err_inc;
  logic       cap_op, cap_ah, cap_al, cap_d;
  logic       ld_tx;
  logic [7:0] tx_val;
  logic       tmo, busy;

`ifdef DBG_TIMEOUT_EN
  dbg_timeout_ctr #(.CYC(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .en     (state == S_GET_AH || state == S_GET_AL ||
             state == S_GET_DATA),
    .kick   (rx_valid),
    .expire (tmo)
  );
`else
  // No timeout: a partial command waits forever.
  assign tmo = (TIMEOUT_CYC < 0);
`endif

  assign busy = (state == S_BUS_WR) || (state == S_BUS_RD) ||
                (state == S_RD_WAIT) || (state == S_TX_REQ) ||
                (state == S_TX_WAIT);

  always_comb begin
    state_n  = state;
    halt_set = 1'b0;
    resume   = 1'b0;
    err_inc  = 1'b0;
    cap_op   = 1'b0;
    cap_ah   = 1'b0;
    cap_al   = 1'b0;
    cap_d    = 1'b0;
    ld_tx    = 1'b0;
    tx_val   = bus_rdata;
    tx_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rx_valid) begin
          unique case (1'b1)
            (rx_data == DBG_HALT):   halt_set = 1'b1;
            (rx_data == DBG_RESUME): resume = 1'b1;
            (rx_data == DBG_WRITE),
            (rx_data == DBG_READ): begin
              cap_op  = 1'b1;
              state_n = S_GET_AH;
            end
            default: err_inc = 1'b1;
          endcase
        end
      end
      S_GET_AH: begin
        if (rx_valid) begin
          cap_ah  = 1'b1;
          state_n = S_GET_AL;
        end else if (tmo) begin
          err_inc = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_GET_AL: begin
        if (rx_valid) begin
          cap_al = 1'b1;
          if (is_wr) begin
            state_n = S_GET_DATA;
          end else if (dbg_grant) begin
            state_n = S_BUS_RD;
          end else begin
            // Reply anyway so the host never blocks on a read.
            ld_tx   = 1'b1;
            tx_val  = DBG_NOHALT_REPLY;
            err_inc = 1'b1;
            state_n = S_TX_REQ;
          end
        end else if (tmo) begin
          err_inc = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (rx_valid) begin
          cap_d = 1'b1;
          if (dbg_grant) begin
            state_n = S_BUS_WR;
          end else begin
            err_inc = 1'b1;
            state_n = S_IDLE;
          end
        end else if (tmo) begin
          err_inc = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_BUS_WR:  state_n = S_IDLE;
      S_BUS_RD:  state_n = S_RD_WAIT;
      S_RD_WAIT: begin
        if (rd_cnt == 2'(READ_LAT)) begin
          ld_tx   = 1'b1;
          state_n = S_TX_REQ;
        end
      end
      S_TX_REQ: begin
        tx_start = 1'b1;
        if (tx_active) state_n = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (!tx_active) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (busy && rx_valid) err_inc = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cpu_halt  <= 1'b0;
      dbg_grant <= 1'b0;
      tx_data   <= 8'h00;
      err_cnt   <= 8'h00;
      addr_q    <= 16'h0000;
      data_q    <= 8'h00;
      is_wr     <= 1'b0;
      rd_cnt    <= 2'd0;
    end else begin
      state <= state_n;
      if (resume) begin
        cpu_halt  <= 1'b0;
        dbg_grant <= 1'b0;
      end else begin
        if (halt_set) cpu_halt <= 1'b1;
        dbg_grant <= cpu_halt;
      end
      if (cap_op) is_wr <= (rx_data == DBG_WRITE);
      if (cap_ah) addr_q[15:8] <= rx_data;
      if (cap_al) addr_q[7:0] <= rx_data;
      if (cap_d) data_q <= rx_data;
      if (ld_tx) tx_data <= tx_val;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (state == S_BUS_RD) rd_cnt <= 2'd1;
      else if (state == S_RD_WAIT) rd_cnt <= rd_cnt + 2'd1;
    end
  end

  always_comb begin
    if (dbg_grant) begin
      bus_addr  = addr_q;
      bus_wdata = data_q;
      bus_we    = (state == S_BUS_WR);
      bus_re    = (state == S_BUS_RD);
    end else begin
      bus_addr  = cpu_addr;
      bus_wdata = cpu_wdata;
      bus_we    = cpu_we;
      bus_re    = cpu_re;
    end
  end

endmodule

// File: tb/tb_uart_dbg_bus_ctrl.sv
// Randomized self-checking bench for uart_dbg_bus_ctrl against a
// command-level model of the debug protocol.
module tb_uart_dbg_bus_ctrl;

  localparam int RL  = 2;
  localparam int TMO = 16;

  logic        clk, rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_active;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we, cpu_re;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we, bus_re;
  logic [7:0]  bus_rdata;
  logic        cpu_halt, dbg_grant;
  logic [7:0]  err_cnt;

  uart_dbg_bus_ctrl #(.READ_LAT(RL), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_active (tx_active),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .cpu_halt  (cpu_halt),
    .dbg_grant (dbg_grant),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd_fn(logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h7D;
  endfunction

  // Memory answers only exactly RL cycles after a read strobe.
  logic [3:0] re_hist;
  always @(posedge clk or posedge rst) begin
    if (rst) re_hist <= '0;
    else re_hist <= {re_hist[2:0], bus_re};
  end
  assign bus_rdata = re_hist[RL-1] ? rd_fn(bus_addr) : 8'hEE;

  logic [23:0] wr_obs[$];
  logic [15:0] rd_obs[$];
  logic [7:0]  tx_obs[$];
  logic [23:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_tx[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (bus_we) wr_obs.push_back({bus_addr, bus_wdata});
      if (bus_re) rd_obs.push_back(bus_addr);
    end
  end

  initial begin
    tx_active = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !tx_active) begin
        tx_obs.push_back(tx_data);
        repeat (2) @(negedge clk);
        tx_active = 1'b1;
        repeat (6) @(negedge clk);
        tx_active = 1'b0;
      end
    end
  end

  int n_chk;
  int n_pass;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  bit m_halt;
  int m_err;

  task automatic m_err_inc();
    if (m_err < 255) m_err++;
  endtask

  task automatic send(logic [7:0] b, int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_tx();
    int n = 0;
    while (tx_obs.size() == 0 && n < 300) begin @(negedge clk); n++; end
    while (!tx_active && n < 300) begin @(negedge clk); n++; end
    while (tx_active && n < 300) begin @(negedge clk); n++; end
    check("tx_done", 32'(n < 300), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_all();
    int nw, nr, nt;
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("cpu_halt", 32'(cpu_halt), 32'(m_halt));
    check("dbg_grant", 32'(dbg_grant), 32'(m_halt));
    check("wr_count", wr_obs.size(), exp_wr.size());
    check("rd_count", rd_obs.size(), exp_rd.size());
    check("tx_count", tx_obs.size(), exp_tx.size());
    nw = (wr_obs.size() < exp_wr.size()) ? wr_obs.size() : exp_wr.size();
    nr = (rd_obs.size() < exp_rd.size()) ? rd_obs.size() : exp_rd.size();
    nt = (tx_obs.size() < exp_tx.size()) ? tx_obs.size() : exp_tx.size();
    for (int i = 0; i < nw; i++) check("wr_txn", 32'(wr_obs[i]), 32'(exp_wr[i]));
    for (int i = 0; i < nr; i++) check("rd_addr", 32'(rd_obs[i]), 32'(exp_rd[i]));
    for (int i = 0; i < nt; i++) check("tx_byte", 32'(tx_obs[i]), 32'(exp_tx[i]));
    wr_obs.delete(); rd_obs.delete(); tx_obs.delete();
    exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
  endtask

  task automatic cpu_rand();
    cpu_addr  = 16'($urandom);
    cpu_wdata = 8'($urandom);
    cpu_we    = 1'($urandom);
    cpu_re    = 1'($urandom);
  endtask

  task automatic cpu_idle();
    cpu_we = 1'b0;
    cpu_re = 1'b0;
  endtask

  task automatic do_cmd(int kind, logic [15:0] a, logic [7:0] d, int g);
    case (kind)
      0: begin
        send(8'h00, 4);
        m_halt = 1'b1;
      end
      1: begin
        cpu_idle();
        send(8'h01, 4);
        m_halt = 1'b0;
      end
      2: begin
        send(8'h02, g); send(a[15:8], g); send(a[7:0], g); send(d, 4);
        if (m_halt) exp_wr.push_back({a, d});
        else m_err_inc();
      end
      3: begin
        send(8'h03, g); send(a[15:8], g); send(a[7:0], 0);
        wait_tx();
        if (m_halt) begin
          exp_rd.push_back(a);
          exp_tx.push_back(rd_fn(a));
        end else begin
          exp_tx.push_back(8'hFF);
          m_err_inc();
        end
      end
      default: begin
        send(8'($urandom_range(4, 255)), g);
        m_err_inc();
      end
    endcase
    if (m_halt) cpu_rand();
    compare_all();
  endtask

  initial begin
    int n;
    n_chk = 0; n_pass = 0;
    m_halt = 1'b0; m_err = 0;
    rx_valid = 1'b0; rx_data = 8'h00;
    cpu_addr = 16'h1234; cpu_wdata = 8'h00;
    cpu_we = 1'b1; cpu_re = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bus_addr", 32'(bus_addr), 32'h1234);
    check("rst_bus_we", 32'(bus_we), 32'd1);
    check("rst_cpu_halt", 32'(cpu_halt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_grant", 32'(dbg_grant), 32'd0);
    check("rst_tx", 32'({tx_start, tx_data}), 32'd0);
    rst = 1'b0;
    cpu_we = 1'b0;
    @(negedge clk);

    send(8'h00, 0);
    check("halt_now", 32'(cpu_halt), 32'd1);
    check("grant_late", 32'(dbg_grant), 32'd0);
    @(negedge clk);
    check("grant_up", 32'(dbg_grant), 32'd1);
    m_halt = 1'b1;
    cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 16'hBEEF;
    @(negedge clk);
    check("cpu_ignored", 32'({bus_we, bus_re, bus_addr}), 32'd0);

    send(8'h02, 2); send(8'h20, 2); send(8'h06, 2); send(8'h3F, 0);
    check("wr_pulse", 32'({bus_we, bus_addr, bus_wdata}), 32'h1_2006_3F);
    @(negedge clk);
    check("wr_end", 32'({bus_we, bus_addr, bus_wdata}), 32'h0_2006_3F);
    exp_wr.push_back({16'h2006, 8'h3F});

    send(8'h03, 2); send(8'h20, 2); send(8'h07, 0);
    check("rd_pulse", 32'({bus_re, bus_addr}), 32'h1_2007);
    @(negedge clk);
    check("rd_end", 32'({bus_re, tx_start}), 32'd0);
    @(negedge clk);
    check("tx_wait_lat", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("tx_start", 32'({tx_start, tx_data}), 32'h1_5A);
    wait_tx();
    exp_rd.push_back(16'h2007);
    exp_tx.push_back(8'h5A);
    compare_all();

    cpu_idle();
    send(8'h01, 0);
    check("resume", 32'({cpu_halt, dbg_grant}), 32'd0);
    m_halt = 1'b0;
    do_cmd(3, 16'h1234, 8'h00, 2);
    check("err_one", 32'(err_cnt), 32'd1);
    do_cmd(4, 16'h0000, 8'h00, 3);
    check("err_two", 32'(err_cnt), 32'd2);

    send(8'h03, 2); send(8'h55, 2); send(8'hAA, 0);
    n = 0;
    while (!tx_active && n < 300) begin @(negedge clk); n++; end
    check("tx_seen", 32'(n < 300), 32'd1);
    send(8'h00, 0);
    wait_tx();
    exp_tx.push_back(8'hFF);
    m_err_inc(); m_err_inc();
    compare_all();

`ifdef DBG_TIMEOUT_EN
    send(8'h02, 2); send(8'h20, 0);
    repeat (TMO + 4) @(negedge clk);
    m_err_inc();
    check("tmo_err", 32'(err_cnt), 32'(m_err));
    do_cmd(0, 16'h0000, 8'h00, 2);
`endif

    for (int i = 0; i < 40; i++) begin
      do_cmd($urandom_range(0, 4), 16'($urandom), 8'($urandom),
             $urandom_range(1, 5));
    end

    cpu_idle();
    send(8'h01, 0);
    check("resume2", 32'({cpu_halt, dbg_grant}), 32'd0);
    m_halt = 1'b0;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom_range(4, 255)), 1);
      m_err_inc();
    end
    compare_all();
    check("err_sat", 32'(err_cnt), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
